// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult_div_unit: sequential radix-2 multiply / restoring divide, with a      |
// | fixed WIDTH+1 cycle latency. Define MULT_DIV_UNSIGNED_EN for MULTU/DIVU.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_q, rneg_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic is_signed, op_legal;
`ifdef MULT_DIV_UNSIGNED_EN
  assign is_signed = ~op[1];
  assign op_legal  = 1'b1;
`else
  assign is_signed = 1'b1;
  assign op_legal  = ~op[1];
`endif

  // Both operations run on magnitudes; signs are reapplied on the last step.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_d = mul_sum[WIDTH:1];
  assign mul_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_hi_d, div_lo_d;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_hi_d  = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod_neg;
  assign step_hi  = div_q ? div_hi_d : mul_hi_d;
  assign step_lo  = div_q ? div_lo_d : mul_lo_d;
  assign prod_neg = -{step_hi, step_lo};

  always_comb begin
    fin_hi = step_hi;
    fin_lo = step_lo;
    if (div_q) begin
      if (neg_q)  fin_lo = -step_lo;
      if (rneg_q) fin_hi = -step_hi;
    end else if (neg_q) begin
      {fin_hi, fin_lo} = prod_neg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && op_legal) begin
            div_q    <= op[0];
            neg_q    <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            acc_hi_q <= '0;
            acc_lo_q <= a_mag;
            opnd_q   <= b_mag;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (op[0] && (b == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width and the hi/lo width; legal values are even numbers from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT (signed), 01 DIV (signed), 10 MULTU, 11 DIVU.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier or divisor.
REQ-008 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port div_zero, output, 1 bit: high together with done when the divisor was zero.
REQ-011 SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-012 SHALL have port lo, output, WIDTH bits: product lower half, or quotient.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 and a legal op SHALL latch a, b and op, clear the iteration counter and enter RUN next cycle.
REQ-015 RUN SHALL perform one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle, for exactly WIDTH cycles, then enter DONE.
REQ-016 DONE SHALL last one cycle, assert done, update hi/lo, then return to IDLE.
REQ-017 Latency SHALL be fixed: done is high in cycle WIDTH+1 after the start cycle, for both multiply and divide.
REQ-018 MULT/MULTU SHALL give {hi,lo} = the full 2*WIDTH-bit product, signed or unsigned per op.
REQ-019 DIV/DIVU SHALL give lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Signed DIV of -2^(WIDTH-1) by -1 SHALL give lo = -2^(WIDTH-1) and hi = 0, with no flag.
REQ-021 Divide with b=0 SHALL skip RUN, go from IDLE to DONE in one cycle, assert done and div_zero, and leave hi/lo unchanged.
REQ-022 start while busy SHALL be ignored; it is neither queued nor allowed to corrupt the latched operands.
REQ-023 hi/lo SHALL hold their last result until the next DONE; they SHALL never show intermediate values.
REQ-024 div_zero SHALL be low in every cycle where done is low.
REQ-025 start and DONE in the same cycle SHALL not be accepted; a new start is accepted in IDLE on the following cycle.

Reset
REQ-026 Reset SHALL force IDLE and clear hi, lo, busy, done, div_zero, the counter and the operand registers to 0, independent of clk.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse; the first cycle after release is IDLE.

Configuration
REQ-028 Macro MULT_DIV_UNSIGNED_EN defined SHALL enable op 10 and op 11 as specified above.
REQ-029 Without MULT_DIV_UNSIGNED_EN, op 1x with start=1 SHALL be ignored (stay IDLE, no done) and the unsigned datapath SHALL not be synthesised.

Verification
REQ-030 WIDTH=32, MULT a=-3 b=7 -> done at cycle 33, hi=FFFFFFFF, lo=FFFFFFEB, div_zero=0.
REQ-031 WIDTH=32, DIV a=-7 b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
REQ-032 DIV b=0 with prior hi=5, lo=9 -> done and div_zero on the next cycle, hi=5, lo=9 unchanged.
REQ-033 start pulsed mid-RUN with new operands -> first result unaffected, exactly one done; reset asserted at RUN cycle 10 -> no done, outputs 0.
REQ-034 With MULT_DIV_UNSIGNED_EN, MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; without the macro, the same op -> no done and busy stays 0.
REQ-035 WIDTH=16, MULT 7FFF*7FFF -> hi=3FFF, lo=0001, done at cycle 17.
